// File: rtl/fetch_pc_unit_if.sv
// Instruction-cache request/response bus between the fetch PC stage (master)
// and the instruction cache (slave).
interface fetch_pc_unit_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;

    modport master (
        output iREN,
        output iaddr,
        input  ihit,
        input  iload
    );

    modport slave (
        input  iREN,
        input  iaddr,
        output ihit,
        output iload
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC stage: holds the fetch PC, issues icache reads, follows predictor
// and EX redirects, and loads the IF/ID latch. A wrong-path miss is drained before redirecting.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    fetch_pc_unit_if.master   ibus,
    input  logic              take_br,
    input  logic [31:0]       br_target,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_npc,
    output logic              if_pred_taken,
    output logic [31:0]       if_pred_target,
    output logic [CNT_W-1:0]  redirect_cnt,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]  state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pending, pending_n;
    logic        iren_q;

    logic        hit;
    logic        if_load;
    logic        if_clear;

    assign ibus.iaddr = pc;
    assign ibus.iREN  = iren_q;

    // A response only counts while a read is actually outstanding.
    assign hit = iren_q && ibus.ihit;

    // NOTE: every signal assigned here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        pending_n = pending;
        if_load   = 1'b0;
        if_clear  = 1'b0;

        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    if_clear = 1'b1;
                    if (ibus.ihit || !iren_q) begin
                        pc_n = redirect_pc;
                    end else begin
                        // The outstanding wrong-path miss must return before pc may move.
                        pending_n = redirect_pc;
                        state_n   = DRAIN;
                    end
                end else if (stall) begin
                    // pc and the IF/ID latch hold; a hit this cycle is refetched later.
                end else if (hit) begin
                    if_load = 1'b1;
                    pc_n    = take_br ? br_target : pc + 32'd4;
                end else begin
                    if_clear = 1'b1;
                end
            end

            DRAIN: begin
                if_clear = 1'b1;
                if (redirect_valid) begin
                    pending_n = redirect_pc;
                end
                if (hit) begin
                    pc_n    = redirect_valid ? redirect_pc : pending;
                    state_n = FETCH;
                end
            end

            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            pending <= 32'd0;
            iren_q  <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            pending <= pending_n;
            iren_q  <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            if_valid       <= 1'b0;
            if_instr       <= 32'd0;
            if_pc          <= 32'd0;
            if_npc         <= 32'd0;
            if_pred_taken  <= 1'b0;
            if_pred_target <= 32'd0;
        end else if (if_load) begin
            if_valid       <= 1'b1;
            if_instr       <= ibus.iload;
            if_pc          <= pc;
            if_npc         <= pc + 32'd4;
            if_pred_taken  <= take_br;
            if_pred_target <= take_br ? br_target : 32'd0;
        end else if (if_clear) begin
            if_valid       <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (if_load && fetch_cnt != CNT_MAX) begin
                fetch_cnt <= fetch_cnt + CNT_ONE;
            end
            if (redirect_valid && redirect_cnt != CNT_MAX) begin
                redirect_cnt <= redirect_cnt + CNT_ONE;
            end
        end
    end

endmodule
